// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MDUControl op codes,
// FSM state encoding, divider modes and default latencies.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;
    localparam logic [3:0] MDU_FDIV  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } mdu_state_t;

    typedef enum logic [1:0] {
        DIV_SIGNED   = 2'd0,
        DIV_UNSIGNED = 2'd1,
        DIV_FLOOR    = 2'd2
    } div_mode_t;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_div_core.sv
// Combinational 32-bit divider. Signed modes divide magnitudes and fix the
// signs afterwards, so 0x80000000 / -1 wraps cleanly to 0x80000000 rem 0.
module mdu_div_core
    import mdu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  div_mode_t   mode,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    logic        sgn;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q_t;
    logic [31:0] r_t;

    assign sgn         = (mode != DIV_UNSIGNED);
    assign neg_a       = sgn & a[31];
    assign neg_b       = sgn & b[31];
    assign mag_a       = neg_a ? (32'd0 - a) : a;
    assign mag_b       = neg_b ? (32'd0 - b) : b;
    assign div_by_zero = (b == 32'd0);

    // Unsigned magnitude divide; zero divisor yields zeros (result is discarded)
    always_comb begin
        uq = 32'd0;
        ur = 32'd0;
        if (!div_by_zero) begin
            uq = mag_a / mag_b;
            ur = mag_a % mag_b;
        end
    end

    assign q_t = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
    assign r_t = neg_a ? (32'd0 - ur) : ur;

    // Floor mode pulls a nonzero remainder onto the divisor's sign
    always_comb begin
        quotient  = q_t;
        remainder = r_t;
        if (mode == DIV_FLOOR && r_t != 32'd0 && (r_t[31] != b[31])) begin
            quotient  = q_t - 32'd1;
            remainder = r_t + b;
        end
    end

endmodule

// File: rtl/mdu_unit.sv
// Execute-stage multiply/divide unit holding HI/LO. Multi-cycle ops sample
// operands on the accepting edge, stay busy for a fixed count, then commit.
// Handshake: Start is high in the cycle an op is accepted (multi-cycle code
// and not Busy); Busy is high in each following cycle until commit, and any
// code presented while Busy has no effect on state.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUControl,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUOut,
    output mdu_state_t  fsm_state
);

    mdu_state_t  state;
    logic [3:0]  cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_wr;

    logic        is_mul;
    logic        is_div;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [63:0] prod;
    div_mode_t   div_mode;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        dbz;
    logic        commit;

    assign is_mul    = (MDUControl == MDU_MULT) || (MDUControl == MDU_MULTU);
    assign is_div    = (MDUControl == MDU_DIV) || (MDUControl == MDU_DIVU) ||
                       (MDUControl == MDU_FDIV);
    assign Busy      = (state != IDLE);
    assign Start     = (is_mul | is_div) & ~Busy;
    assign fsm_state = state;
    assign commit    = Busy && (cnt == 4'd1);

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};
    assign prod   = (MDUControl == MDU_MULT) ? prod_s : prod_u;

    // Map the op code onto the divider mode
    always_comb begin
        div_mode = DIV_SIGNED;
        if (MDUControl == MDU_DIVU) div_mode = DIV_UNSIGNED;
        else if (MDUControl == MDU_FDIV) div_mode = DIV_FLOOR;
    end

    mdu_div_core u_div (
        .a           (A),
        .b           (B),
        .mode        (div_mode),
        .quotient    (quo),
        .remainder   (rem),
        .div_by_zero (dbz)
    );

    // FSM, busy counter and pending result capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start && is_mul) begin
                        state   <= MUL;
                        cnt     <= MULT_CYCLES[3:0];
                        pend_hi <= prod[63:32];
                        pend_lo <= prod[31:0];
                        pend_wr <= 1'b1;
                    end else if (Start) begin
                        state   <= DIV;
                        cnt     <= DIV_CYCLES[3:0];
                        pend_hi <= rem;
                        pend_lo <= quo;
                        pend_wr <= ~dbz;
                    end
                end
                default: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= IDLE;
                end
            endcase
        end
    end

    // HI/LO: commit of pending results, or direct writes while idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            HI <= 32'd0;
            LO <= 32'd0;
        end else if (commit) begin
            if (pend_wr) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end
        end else if (!Busy && MDUControl == MDU_MTHI) begin
            HI <= A;
        end else if (!Busy && MDUControl == MDU_MTLO) begin
            LO <= A;
        end
    end

    // Read port for mfhi/mflo
    always_comb begin
        MDUOut = 32'd0;
        if (MDUControl == MDU_MFHI) MDUOut = HI;
        else if (MDUControl == MDU_MFLO) MDUOut = LO;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Execute-stage multiply/divide unit. Consumes the 4-bit MDUControl code produced by the decoder, plus forwarded rs/rt operands.
- Performs mult/multu/div/divu/fdiv with fixed multi-cycle latency and holds the HI/LO registers.
- Serves mfhi/mflo reads and mthi/mtlo writes.
- Exports Start/Busy so the hazard unit can stall md/mf/mt instructions in D.

Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, Busy cycles for div/divu/fdiv (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- MDUControl  input  4  op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 fdiv, 10..15 none.
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- Start  output  1  combinational; high in the cycle a multi-cycle op is accepted.
- Busy  output  1  registered; high while a multi-cycle op is in flight.
- HI  output  32  current HI register.
- LO  output  32  current LO register.
- MDUOut  output  32  combinational read data: HI for code 5, LO for code 6, otherwise 0.

Behaviour:
- Reset (reset==0, asynchronous): state IDLE, counter 0, HI=0, LO=0, pending results 0, Busy=0.
  - Reset mid-operation discards the in-flight result.
- Start = (code in {1,2,3,4,9}) & ~Busy.
- States:
  - IDLE -> MUL on Start with code 1/2: counter=MULT_CYCLES.
  - IDLE -> DIV on Start with code 3/4/9: counter=DIV_CYCLES.
  - MUL/DIV: counter decrements each cycle. When counter==1, commit pending HI/LO and return to IDLE.
- Busy = (state != IDLE).
- Timing: op accepted in cycle 0 is busy in cycles 1..N. HI/LO carry the new value from cycle N+1. mfhi in cycle N+1 returns the new HI.
- Results are computed from A/B sampled at the accepting edge. Later operand changes have no effect.
- mult: signed 64-bit product; HI=[63:32], LO=[31:0]. multu: same, unsigned.
- div: signed, quotient truncated toward zero; LO=quotient, HI=remainder (sign of dividend).
  - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- divu: unsigned; LO=quotient, HI=remainder.
- fdiv: signed floor division. Start from the truncated q, r. If r!=0 and sign(r)!=sign(B): q=q-1, r=r+B. Then LO=q, HI=r.
- Divide by zero (B==0, codes 3/4/9): full DIV_CYCLES busy period still runs; HI/LO left unchanged at commit.
- mthi/mtlo (7/8) while IDLE: HI (resp. LO) <= A at the next edge; MDUOut=0.
- Any code arriving while Busy is ignored. No accept, no write, no Start, and MDUOut still reads current HI/LO for 5/6. The hazard unit guarantees this never occurs in normal flow.
- Codes 0 and 10..15: no state change, MDUOut=0.
- No back-to-back overlap: a new op can be accepted in cycle N+1 at the earliest.

Decomposition:
- Package mdu_pkg holds:
  - op-code constants MDU_NONE..MDU_FDIV (same encoding as the decoder's MDUControl);
  - state enum {IDLE, MUL, DIV};
  - default latency constants.
- Sub-module mdu_div_core: combinational 32-bit divider.
  - Inputs: A, B, mode {signed, unsigned, floor}.
  - Outputs: quotient, remainder, div_by_zero.
  - Instantiated once; sampled at the accepting edge.

Test Plan:
- mult A=0xFFFFFFFE(-2), B=3 -> Start=1 cycle 0; Busy=1 cycles 1..5; cycle 6 HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=0x00000001, LO=0xFFFFFFFE. mflo in cycle 6 gives MDUOut=0xFFFFFFFE.
- div A=-7, B=2 -> LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). fdiv same operands -> LO=0xFFFFFFFC(-4), HI=0x00000001. Busy 10 cycles each.
- divu A=100, B=0 with HI=0x11, LO=0x22 beforehand -> Busy 10 cycles, then HI=0x11, LO=0x22 unchanged.
- mthi A=0xDEADBEEF then mfhi next cycle -> MDUOut=0xDEADBEEF. A mult issued while Busy (cycle 3 of a div) -> Start=0, result of div only.
- reset pulled low in cycle 4 of a mult -> Busy=0, HI=LO=0 immediately. After release, idle with Start=0 until a new op arrives.
